// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C read master: the controller state encoding,
// the R/W bit value that selects a read, and the default target address.
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        ADDR,
        AACK,
        READ,
        MACK,
        STOP
    } state_t;

    localparam logic       I2C_RD_BIT       = 1'b1;
    localparam logic [6:0] I2C_DEFAULT_ADDR = 7'h40;

endpackage

// File: rtl/i2c_qtick.sv
// Quarter-period tick generator for the I2C master. It counts system clocks
// 0..CLK_DIV-1 and pulses tick on the wrap. clr holds the count at zero so that
// every transaction begins with a full quarter period before the first bus change.
module i2c_qtick #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int            CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = !clr && (cnt == LAST);

    // Free-running divider, restarted on wrap or while held clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/i2c_master_rd.sv
// Fixed-length I2C read master: START, address + R, NBYTES data bytes with
// master ACK (NACK on the last byte), STOP. SCL/SDA are open-drain style levels
// (1 = released). Every bus change happens on a quarter tick; a bit cell is four
// quarters: Q0 SCL low + SDA update, Q1/Q2 SCL high (sample on Q2), Q3 SCL low.
// Optional feature: define I2C_MASTER_RD_RETRY_EN to re-issue STOP/START after an
// address NACK, up to RETRY_MAX extra attempts, before reporting ack_err.
module i2c_master_rd
    import i2c_pkg::*;
#(
    parameter int         CLK_DIV    = 4,
    parameter logic [6:0] SLAVE_ADDR = I2C_DEFAULT_ADDR,
    parameter int         NBYTES     = 2,
    parameter int         RETRY_MAX  = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       sda_in,
    output logic       scl,
    output logic       sda_out,
    output logic       busy,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       done,
    output logic       ack_err
);

    localparam int         BW        = $clog2(NBYTES + 1);
    localparam logic [7:0] ADDR_BYTE = {SLAVE_ADDR, I2C_RD_BIT};

    state_t        state;
    logic [1:0]    q;
    logic [2:0]    bit_cnt;
    logic [BW-1:0] byte_cnt;
    logic [7:0]    shreg;
    logic          addr_nack;
    logic          retry;
    logic          tick;
    logic          cell_sda;
    logic          last_byte;
    logic          can_retry;

`ifdef I2C_MASTER_RD_RETRY_EN
    localparam int RW = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;
    logic [RW-1:0] retry_cnt;
    assign can_retry = (retry_cnt != RW'(RETRY_MAX));
`else
    assign can_retry = 1'b0;
`endif

    // byte_cnt is bumped at the end of each READ, so in MACK it already
    // counts the byte just received.
    assign last_byte = (byte_cnt == BW'(NBYTES));

    i2c_qtick #(.CLK_DIV(CLK_DIV)) u_qtick (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (state == IDLE),
        .tick  (tick)
    );

    // SDA level the master presents during Q0 of a data-type bit cell.
    always_comb begin
        cell_sda = 1'b1;
        if (state == ADDR) begin
            cell_sda = ADDR_BYTE[3'd7 - bit_cnt];
        end else if (state == MACK) begin
            cell_sda = last_byte;
        end
    end

    // Transaction controller: walks the quarter phases of each cell and
    // drives the registered bus levels and host strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            q         <= '0;
            bit_cnt   <= '0;
            byte_cnt  <= '0;
            shreg     <= '0;
            addr_nack <= 1'b0;
            retry     <= 1'b0;
            scl       <= 1'b1;
            sda_out   <= 1'b1;
            busy      <= 1'b0;
            rd_data   <= '0;
            rd_valid  <= 1'b0;
            done      <= 1'b0;
            ack_err   <= 1'b0;
`ifdef I2C_MASTER_RD_RETRY_EN
            retry_cnt <= '0;
`endif
        end else begin
            rd_valid <= 1'b0;
            done     <= 1'b0;
            if (state == IDLE) begin
                if (start) begin
                    state     <= START;
                    busy      <= 1'b1;
                    ack_err   <= 1'b0;
                    q         <= '0;
                    bit_cnt   <= '0;
                    byte_cnt  <= '0;
                    addr_nack <= 1'b0;
                    retry     <= 1'b0;
`ifdef I2C_MASTER_RD_RETRY_EN
                    retry_cnt <= '0;
`endif
                end
            end else if (tick) begin
                q <= q + 2'd1;
                case (state)
                    START: begin
                        case (q)
                            2'd0:    begin scl <= 1'b1; sda_out <= 1'b1; end
                            2'd1:    sda_out <= 1'b0;
                            default: scl <= 1'b0;
                        endcase
                        if (q == 2'd3) state <= ADDR;
                    end
                    STOP: begin
                        case (q)
                            2'd0:    begin scl <= 1'b0; sda_out <= 1'b0; end
                            2'd1:    scl <= 1'b1;
                            default: begin scl <= 1'b1; sda_out <= 1'b1; end
                        endcase
                        if (q == 2'd3) begin
                            if (retry) begin
                                state     <= START;
                                retry     <= 1'b0;
                                addr_nack <= 1'b0;
`ifdef I2C_MASTER_RD_RETRY_EN
                                retry_cnt <= retry_cnt + RW'(1);
`endif
                            end else begin
                                state   <= IDLE;
                                busy    <= 1'b0;
                                done    <= 1'b1;
                                ack_err <= addr_nack;
                            end
                        end
                    end
                    default: begin
                        // ADDR/AACK/READ/MACK share the same cell shape. The
                        // Q2 sample always shifts in; in AACK the ack bit lands
                        // in shreg[0], and READ overwrites all eight bits.
                        case (q)
                            2'd0:    begin scl <= 1'b0; sda_out <= cell_sda; end
                            2'd1:    scl <= 1'b1;
                            2'd2:    begin scl <= 1'b1; shreg <= {shreg[6:0], sda_in}; end
                            default: scl <= 1'b0;
                        endcase
                        if (q == 2'd3) begin
                            case (state)
                                ADDR: begin
                                    bit_cnt <= bit_cnt + 3'd1;
                                    if (bit_cnt == 3'd7) state <= AACK;
                                end
                                AACK: begin
                                    if (!shreg[0]) begin
                                        state <= READ;
                                    end else begin
                                        state     <= STOP;
                                        addr_nack <= 1'b1;
                                        retry     <= can_retry;
                                    end
                                end
                                READ: begin
                                    bit_cnt <= bit_cnt + 3'd1;
                                    if (bit_cnt == 3'd7) begin
                                        rd_data  <= shreg;
                                        rd_valid <= 1'b1;
                                        byte_cnt <= byte_cnt + BW'(1);
                                        state    <= MACK;
                                    end
                                end
                                MACK:    state <= last_byte ? STOP : READ;
                                default: state <= IDLE;
                            endcase
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_master_rd.sv
// Bench for i2c_master_rd: two instances (CLK_DIV=1/NBYTES=2 and
// CLK_DIV=3/NBYTES=1), each on its own bus with a protocol-level slave model
// that decodes START/STOP/bits from the SCL/SDA levels and answers with
// randomized data bytes.
module tb_i2c_master_rd;

    localparam int CD0 = 1, NB0 = 2, CD1 = 3, NB1 = 1, RMAX = 3;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] start_v = '0;
    logic [1:0] scl_v, sdao_v, busy_v, rdv_v, done_v, aerr_v;
    logic [1:0] drv_v = 2'b11;
    logic [7:0] rdd [2];

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // slave configuration (written by the test sequence only)
    int         present    [2];
    int         nack_until [2];
    logic [7:0] sdata      [2][4];

    // bus observations (written by the watcher only)
    int         starts [2], stops [2], rises [2], attempts [2];
    int         nmack [2], nvalid [2], ndone [2], done_cyc [2];
    logic       acked [2], mnack [2], prev_scl [2], prev_sda [2];
    logic [7:0] addr_rx [2];
    logic       mack_log [2][16];
    logic [7:0] vdata [2][16];

    always #5 clk = ~clk;

    i2c_master_rd #(.CLK_DIV(CD0), .SLAVE_ADDR(7'h40), .NBYTES(NB0), .RETRY_MAX(RMAX)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .sda_in(sdao_v[0] & drv_v[0]),
        .scl(scl_v[0]), .sda_out(sdao_v[0]), .busy(busy_v[0]), .rd_data(rdd[0]),
        .rd_valid(rdv_v[0]), .done(done_v[0]), .ack_err(aerr_v[0]));

    i2c_master_rd #(.CLK_DIV(CD1), .SLAVE_ADDR(7'h40), .NBYTES(NB1), .RETRY_MAX(RMAX)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .sda_in(sdao_v[1] & drv_v[1]),
        .scl(scl_v[1]), .sda_out(sdao_v[1]), .busy(busy_v[1]), .rd_data(rdd[1]),
        .rd_valid(rdv_v[1]), .done(done_v[1]), .ack_err(aerr_v[1]));

    initial begin : cycle_count
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Slave model + monitor: slot k after START is the k-th SCL high period.
    // Slots 0..7 address, 8 address ack, then per byte 8 data slots + 1 master ack.
    initial begin : watch
        logic sl, dl;
        int   r, b;
        for (int i = 0; i < 2; i++) begin
            starts[i] = 0; stops[i] = 0; rises[i] = 0; attempts[i] = 0;
            nmack[i] = 0; nvalid[i] = 0; ndone[i] = 0; done_cyc[i] = 0;
            acked[i] = 1'b0; mnack[i] = 1'b0; prev_scl[i] = 1'b1; prev_sda[i] = 1'b1;
            addr_rx[i] = '0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                sl = scl_v[i];
                dl = sdao_v[i] & drv_v[i];
                if (!rst_n) begin
                    rises[i] = 0; acked[i] = 1'b0; mnack[i] = 1'b0; drv_v[i] = 1'b1;
                end else if (prev_scl[i] && sl && prev_sda[i] && !dl) begin
                    starts[i]++; rises[i] = 0; acked[i] = 1'b0; mnack[i] = 1'b0; drv_v[i] = 1'b1;
                end else if (prev_scl[i] && sl && !prev_sda[i] && dl) begin
                    stops[i]++; acked[i] = 1'b0; drv_v[i] = 1'b1;
                end else if (!prev_scl[i] && sl) begin
                    if (rises[i] < 8) begin
                        addr_rx[i] = {addr_rx[i][6:0], dl};
                    end else if (acked[i] && rises[i] >= 9 && (rises[i] - 9) % 9 == 8) begin
                        mack_log[i][nmack[i] % 16] = dl;
                        nmack[i]++;
                        if (dl) mnack[i] = 1'b1;
                    end
                    rises[i]++;
                end else if (prev_scl[i] && !sl) begin
                    drv_v[i] = 1'b1;
                    if (rises[i] == 8) begin
                        if (present[i] != 0 && addr_rx[i] == 8'h81) begin
                            attempts[i]++;
                            if (attempts[i] > nack_until[i]) begin
                                drv_v[i] = 1'b0;
                                acked[i] = 1'b1;
                            end
                        end
                    end else if (acked[i] && !mnack[i] && rises[i] >= 9) begin
                        r = (rises[i] - 9) % 9;
                        b = (rises[i] - 9) / 9;
                        if (r < 8 && b < 4) drv_v[i] = sdata[i][b][7 - r];
                    end
                end
                if (rdv_v[i]) begin
                    vdata[i][nvalid[i] % 16] = rdd[i];
                    nvalid[i]++;
                end
                if (done_v[i]) begin
                    ndone[i]++;
                    done_cyc[i] = cyc;
                end
                prev_scl[i] = sl;
                prev_sda[i] = dl;
            end
        end
    end

    task automatic pulse_start(input int i, output int t0);
        @(negedge clk);
        start_v[i] = 1'b1;
        t0 = cyc + 1;
        @(negedge clk);
        start_v[i] = 1'b0;
    endtask

    task automatic wait_done(input int i, input int base, input int budget, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            #1;
            if (ndone[i] != base) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            checks++; if (scl_v[i] !== 1'b1) begin errors++; $display("FAIL reset_scl[%0d]: got %b want 1", i, scl_v[i]); end
            checks++; if (sdao_v[i] !== 1'b1) begin errors++; $display("FAIL reset_sda[%0d]: got %b want 1", i, sdao_v[i]); end
            checks++; if (busy_v[i] !== 1'b0) begin errors++; $display("FAIL reset_busy[%0d]: got %b want 0", i, busy_v[i]); end
            checks++; if (rdd[i] !== 8'h00) begin errors++; $display("FAIL reset_rd_data[%0d]: got %h want 00", i, rdd[i]); end
            checks++; if (rdv_v[i] !== 1'b0) begin errors++; $display("FAIL reset_rd_valid[%0d]: got %b want 0", i, rdv_v[i]); end
            checks++; if (done_v[i] !== 1'b0) begin errors++; $display("FAIL reset_done[%0d]: got %b want 0", i, done_v[i]); end
            checks++; if (aerr_v[i] !== 1'b0) begin errors++; $display("FAIL reset_ack_err[%0d]: got %b want 0", i, aerr_v[i]); end
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_read(input int i, input int cd, input int nb);
        int         t0, s0, p0, v0, m0, d0, lat, exp_len;
        bit         ok;
        logic [7:0] exp_q[$];
        logic       exp_m;
        present[i]    = 1;
        nack_until[i] = attempts[i];
        for (int b = 0; b < 4; b++) sdata[i][b] = 8'($urandom_range(0, 255));
        for (int b = 0; b < nb; b++) exp_q.push_back(sdata[i][b]);
        s0 = starts[i]; p0 = stops[i]; v0 = nvalid[i]; m0 = nmack[i]; d0 = ndone[i];
        exp_len = (2 + 9 * (1 + nb)) * 4 * cd;
        repeat ($urandom_range(0, 5)) @(negedge clk);
        pulse_start(i, t0);
        #1;
        checks++; if (busy_v[i] !== 1'b1) begin errors++; $display("FAIL read_busy_on[%0d]: got %b want 1", i, busy_v[i]); end
        wait_done(i, d0, exp_len + 4 * cd + 20, ok);
        checks++; if (!ok) begin errors++; $display("FAIL read_done_timeout[%0d]: got no done want done", i); end
        lat = done_cyc[i] - t0;
        checks++; if (lat < exp_len - cd || lat > exp_len + cd) begin errors++; $display("FAIL read_length[%0d]: got %0d want %0d+-%0d", i, lat, exp_len, cd); end
        checks++; if (busy_v[i] !== 1'b0) begin errors++; $display("FAIL read_busy_off[%0d]: got %b want 0", i, busy_v[i]); end
        checks++; if (aerr_v[i] !== 1'b0) begin errors++; $display("FAIL read_ack_err[%0d]: got %b want 0", i, aerr_v[i]); end
        checks++; if (nvalid[i] - v0 != nb) begin errors++; $display("FAIL read_valid_count[%0d]: got %0d want %0d", i, nvalid[i] - v0, nb); end
        for (int b = 0; b < nb; b++) begin
            checks++; if (vdata[i][(v0 + b) % 16] !== exp_q[b]) begin errors++; $display("FAIL read_byte[%0d][%0d]: got %h want %h", i, b, vdata[i][(v0 + b) % 16], exp_q[b]); end
        end
        checks++; if (addr_rx[i] !== 8'h81) begin errors++; $display("FAIL read_addr[%0d]: got %h want 81", i, addr_rx[i]); end
        checks++; if (starts[i] - s0 != 1 || stops[i] - p0 != 1) begin errors++; $display("FAIL read_start_stop[%0d]: got %0d/%0d want 1/1", i, starts[i] - s0, stops[i] - p0); end
        checks++; if (nmack[i] - m0 != nb) begin errors++; $display("FAIL read_mack_count[%0d]: got %0d want %0d", i, nmack[i] - m0, nb); end
        for (int b = 0; b < nb; b++) begin
            exp_m = (b == nb - 1);
            checks++; if (mack_log[i][(m0 + b) % 16] !== exp_m) begin errors++; $display("FAIL read_mack[%0d][%0d]: got %b want %b", i, b, mack_log[i][(m0 + b) % 16], exp_m); end
        end
    endtask

    task automatic test_no_slave();
        int t0, s0, v0, d0, lat, exp_starts;
        bit ok;
        present[0] = 0;
        s0 = starts[0]; v0 = nvalid[0]; d0 = ndone[0];
`ifdef I2C_MASTER_RD_RETRY_EN
        exp_starts = RMAX + 1;
`else
        exp_starts = 1;
`endif
        pulse_start(0, t0);
        wait_done(0, d0, 44 * CD0 * (RMAX + 2) + 50, ok);
        checks++; if (!ok) begin errors++; $display("FAIL nack_done_timeout: got no done want done"); end
        lat = done_cyc[0] - t0;
`ifndef I2C_MASTER_RD_RETRY_EN
        checks++; if (lat < 44 * CD0 - CD0 || lat > 44 * CD0 + CD0) begin errors++; $display("FAIL nack_length: got %0d want %0d+-%0d", lat, 44 * CD0, CD0); end
`endif
        checks++; if (aerr_v[0] !== 1'b1) begin errors++; $display("FAIL nack_ack_err: got %b want 1", aerr_v[0]); end
        checks++; if (starts[0] - s0 != exp_starts) begin errors++; $display("FAIL nack_starts: got %0d want %0d", starts[0] - s0, exp_starts); end
        checks++; if (nvalid[0] != v0) begin errors++; $display("FAIL nack_no_valid: got %0d want 0", nvalid[0] - v0); end
        repeat (20) @(negedge clk);
        #1;
        checks++; if (aerr_v[0] !== 1'b1 || ndone[0] - d0 != 1) begin errors++; $display("FAIL nack_ack_err_hold: got %b/%0d want 1/1", aerr_v[0], ndone[0] - d0); end
    endtask

    task automatic test_nack_retry();
        int t0, s0, v0, d0, exp_starts, exp_valid;
        logic exp_err;
        bit ok;
        present[0]    = 1;
        nack_until[0] = attempts[0] + 1;
        for (int b = 0; b < 4; b++) sdata[0][b] = 8'($urandom_range(0, 255));
        s0 = starts[0]; v0 = nvalid[0]; d0 = ndone[0];
`ifdef I2C_MASTER_RD_RETRY_EN
        exp_starts = 2; exp_valid = NB0; exp_err = 1'b0;
`else
        exp_starts = 1; exp_valid = 0; exp_err = 1'b1;
`endif
        pulse_start(0, t0);
        wait_done(0, d0, 2000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL retry_done_timeout: got no done want done"); end
        checks++; if (aerr_v[0] !== exp_err) begin errors++; $display("FAIL retry_ack_err: got %b want %b", aerr_v[0], exp_err); end
        checks++; if (starts[0] - s0 != exp_starts) begin errors++; $display("FAIL retry_starts: got %0d want %0d", starts[0] - s0, exp_starts); end
        checks++; if (nvalid[0] - v0 != exp_valid) begin errors++; $display("FAIL retry_valid_count: got %0d want %0d", nvalid[0] - v0, exp_valid); end
        if (exp_valid == NB0) begin
            checks++; if (vdata[0][v0 % 16] !== sdata[0][0]) begin errors++; $display("FAIL retry_byte0: got %h want %h", vdata[0][v0 % 16], sdata[0][0]); end
        end
    endtask

    task automatic test_start_held();
        int s0, v0, d0;
        bit ok;
        present[0]    = 1;
        nack_until[0] = attempts[0];
        for (int b = 0; b < 4; b++) sdata[0][b] = 8'($urandom_range(0, 255));
        s0 = starts[0]; v0 = nvalid[0]; d0 = ndone[0];
        @(negedge clk);
        start_v[0] = 1'b1;
        @(negedge clk);
        #1;
        checks++; if (aerr_v[0] !== 1'b0 || busy_v[0] !== 1'b1) begin errors++; $display("FAIL held_accept: got err=%b busy=%b want 0/1", aerr_v[0], busy_v[0]); end
        wait_done(0, d0, 1000, ok);
        start_v[0] = 1'b0;
        checks++; if (!ok) begin errors++; $display("FAIL held_done_timeout: got no done want done"); end
        repeat (60) @(negedge clk);
        #1;
        checks++; if (ndone[0] - d0 != 1 || starts[0] - s0 != 1) begin errors++; $display("FAIL held_single_txn: got done=%0d starts=%0d want 1/1", ndone[0] - d0, starts[0] - s0); end
        checks++; if (busy_v[0] !== 1'b0) begin errors++; $display("FAIL held_busy_off: got %b want 0", busy_v[0]); end
        checks++; if (nvalid[0] - v0 != NB0) begin errors++; $display("FAIL held_valid_count: got %0d want %0d", nvalid[0] - v0, NB0); end
    endtask

    task automatic test_reset_mid();
        int  t0, v0, d0;
        bit  ok;
        present[0]    = 1;
        nack_until[0] = attempts[0];
        for (int b = 0; b < 4; b++) sdata[0][b] = 8'($urandom_range(0, 255));
        v0 = nvalid[0]; d0 = ndone[0];
        pulse_start(0, t0);
        ok = 1'b0;
        for (int k = 0; k < 500; k++) begin
            @(negedge clk);
            #1;
            if (rises[0] >= 14) begin
                ok = 1'b1;
                break;
            end
        end
        checks++; if (!ok) begin errors++; $display("FAIL rstmid_reach_read: got rises=%0d want 14", rises[0]); end
        rst_n = 1'b0;
        #1;
        checks++; if (scl_v[0] !== 1'b1 || sdao_v[0] !== 1'b1) begin errors++; $display("FAIL rstmid_bus: got scl=%b sda=%b want 1/1", scl_v[0], sdao_v[0]); end
        checks++; if (busy_v[0] !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy_v[0]); end
        repeat (20) @(negedge clk);
        #1;
        checks++; if (nvalid[0] != v0 || ndone[0] != d0) begin errors++; $display("FAIL rstmid_quiet: got valid=%0d done=%0d want 0/0", nvalid[0] - v0, ndone[0] - d0); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "bench timeout");
    end

    initial begin : main
        for (int i = 0; i < 2; i++) begin
            present[i] = 0;
            nack_until[i] = 0;
            for (int b = 0; b < 4; b++) sdata[i][b] = 8'h00;
        end
        test_reset();
        test_read(0, CD0, NB0);
        test_read(0, CD0, NB0);
        test_read(1, CD1, NB1);
        test_no_slave();
        test_nack_retry();
        test_start_held();
        test_reset_mid();
        test_read(0, CD0, NB0);
        test_read(1, CD1, NB1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
